// File: rtl/sram_8x36_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sram_8x36_port_arbiter                                                     |
// | Shares one 8x36 1RW SRAM port between a write client and a read client,    |
// | round-robin on conflict, with a 2-entry response FIFO for read returns.    |
// | Optional post-reset zero-fill of the array: define SRAM_ARB_INIT_EN.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sram_8x36_port_arbiter (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        w_valid,
  output logic        w_ready,
  input  logic [2:0]  w_addr,
  input  logic [35:0] w_data,
  input  logic        r_req_valid,
  output logic        r_req_ready,
  input  logic [2:0]  r_addr,
  output logic        r_resp_valid,
  input  logic        r_resp_ready,
  output logic [35:0] r_resp_data,
  output logic        init_done,
  output logic [2:0]  rw_addr,
  output logic        rw_en,
  output logic        rw_wmode,
  output logic [35:0] rw_wdata,
  input  logic [35:0] rw_rdata
);

  localparam logic [1:0] c_ST_RESET = 2'd0;
`ifdef SRAM_ARB_INIT_EN
  localparam logic [1:0] c_ST_INIT  = 2'd1;
`endif
  localparam logic [1:0] c_ST_RUN   = 2'd2;

  localparam logic c_GR_WRITE = 1'b0;
  localparam logic c_GR_READ  = 1'b1;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic        r_last_grant;
  logic        r_inflight;
  logic [35:0] r_fifo_mem [2];
  logic        r_wr_ptr;
  logic        r_rd_ptr;
  logic [1:0]  r_fifo_cnt;

  logic        w_run;
  logic        w_pop;
  logic        w_push;
  logic [2:0]  w_occ;
  logic        w_credit;
  logic        w_wr_elig;
  logic        w_rd_elig;
  logic        w_gnt_wr;
  logic        w_gnt_rd;

`ifdef SRAM_ARB_INIT_EN
  logic [2:0]  r_init_cnt;
`endif

  // ---------------------------------------------------------------- FSM state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_ST_RESET;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
`ifdef SRAM_ARB_INIT_EN
      c_ST_RESET: w_state_nxt = c_ST_INIT;
      c_ST_INIT:  w_state_nxt = (r_init_cnt == 3'd7) ? c_ST_RUN : c_ST_INIT;
`else
      c_ST_RESET: w_state_nxt = c_ST_RUN;
`endif
      c_ST_RUN:   w_state_nxt = c_ST_RUN;
      default:    w_state_nxt = c_ST_RESET;
    endcase
  end

`ifdef SRAM_ARB_INIT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_init_cnt <= 3'd0;
    end else if (r_state == c_ST_INIT) begin
      r_init_cnt <= r_init_cnt + 3'd1;
    end
  end
`endif

  // ---------------------------------------------------------------- arbitration
  assign w_run    = (r_state == c_ST_RUN);
  assign w_pop    = r_resp_valid & r_resp_ready;
  assign w_push   = r_inflight;
  // Slots already committed (stored + returning), minus the one leaving now.
  assign w_occ    = {1'b0, r_fifo_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_credit = (w_occ < 3'd2);

  always_comb begin
    w_wr_elig = w_run & w_valid;
    w_rd_elig = w_run & r_req_valid & w_credit;
    w_gnt_wr  = 1'b0;
    w_gnt_rd  = 1'b0;
    if (w_wr_elig && w_rd_elig) begin
      if (r_last_grant == c_GR_WRITE) begin
        w_gnt_rd = 1'b1;
      end else begin
        w_gnt_wr = 1'b1;
      end
    end else begin
      w_gnt_wr = w_wr_elig;
      w_gnt_rd = w_rd_elig;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant <= c_GR_WRITE;
      r_inflight   <= 1'b0;
    end else begin
      if (w_wr_elig && w_rd_elig) begin
        r_last_grant <= w_gnt_rd ? c_GR_READ : c_GR_WRITE;
      end
      r_inflight <= w_gnt_rd;
    end
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    w_ready     = w_gnt_wr;
    r_req_ready = w_gnt_rd;
    init_done   = w_run;
    rw_en       = w_gnt_wr | w_gnt_rd;
    rw_wmode    = w_gnt_wr;
    rw_addr     = w_gnt_wr ? w_addr : r_addr;
    rw_wdata    = w_data;
`ifdef SRAM_ARB_INIT_EN
    if (r_state == c_ST_INIT) begin
      rw_en    = 1'b1;
      rw_wmode = 1'b1;
      rw_addr  = r_init_cnt;
      rw_wdata = 36'h0;
    end
`endif
  end

  // ---------------------------------------------------------------- response FIFO
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= rw_rdata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_fifo_cnt <= 2'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 2'd1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 2'd1;
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  assign r_resp_valid = (r_fifo_cnt != 2'd0);
  assign r_resp_data  = r_fifo_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_sram_8x36_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sram_8x36_port_arbiter                                                  |
// | Bench for sram_8x36_port_arbiter with a behavioural 8x36 1RW SRAM.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_sram_8x36_port_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        w_valid, w_ready;
  logic [2:0]  w_addr;
  logic [35:0] w_data;
  logic        r_req_valid, r_req_ready;
  logic [2:0]  r_addr;
  logic        r_resp_valid, r_resp_ready;
  logic [35:0] r_resp_data;
  logic        init_done;
  logic [2:0]  rw_addr;
  logic        rw_en, rw_wmode;
  logic [35:0] rw_wdata, rw_rdata;

  int n_vec = 0;
  int n_err = 0;

  logic [35:0] sram [8];
  logic [35:0] ref_mem [8];
  logic [35:0] exp_q [$];
  logic        hold_q = 1'b0;
  logic [35:0] hold_d = '0;

  typedef struct {
    logic        wv;
    logic [2:0]  wa;
    logic [35:0] wd;
    logic        rv;
    logic [2:0]  ra;
    logic        rr;
    logic        e_wrdy;
    logic        e_rrdy;
    logic        e_rvld;
    logic        e_en;
    logic        e_wm;
  } vec_t;

  vec_t tbl [18];

  sram_8x36_port_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr), .w_data(w_data),
    .r_req_valid(r_req_valid), .r_req_ready(r_req_ready), .r_addr(r_addr),
    .r_resp_valid(r_resp_valid), .r_resp_ready(r_resp_ready), .r_resp_data(r_resp_data),
    .init_done(init_done), .rw_addr(rw_addr), .rw_en(rw_en), .rw_wmode(rw_wmode),
    .rw_wdata(rw_wdata), .rw_rdata(rw_rdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (rw_en) begin
      if (rw_wmode) sram[rw_addr] <= rw_wdata;
      else          rw_rdata <= sram[rw_addr];
    end
  end

  task automatic chk(input string nm, input logic [35:0] act, input logic [35:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h required %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard: expected read data queued on accept, compared on pop.
  always @(negedge clock) begin
    if (!reset_n) begin
      exp_q.delete();
      hold_q = 1'b0;
`ifdef SRAM_ARB_INIT_EN
      for (int k = 0; k < 8; k++) ref_mem[k] = 36'h0;
`endif
    end else begin
      if (hold_q) begin
        chk("resp_hold_valid", {35'h0, r_resp_valid}, 36'h1);
        chk("resp_hold_data", r_resp_data, hold_d);
      end
      if (r_resp_valid && r_resp_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL resp_unexpected: got %h required no response", r_resp_data);
        end else begin
          chk("resp_data", r_resp_data, exp_q.pop_front());
        end
      end
      if (r_req_valid && r_req_ready) exp_q.push_back(ref_mem[r_addr]);
      if (w_valid && w_ready) ref_mem[w_addr] = w_data;
      hold_q = r_resp_valid && !r_resp_ready;
      hold_d = r_resp_data;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    w_valid = 1'b0; w_addr = 3'd0; w_data = 36'h0;
    r_req_valid = 1'b0; r_addr = 3'd0; r_resp_ready = 1'b1;
  endtask

  // Called just after reset_n rises; leaves the bench on a negedge.
  task automatic check_init();
    @(negedge clock);
    chk("rst_state_en", {35'h0, rw_en}, 36'h0);
    chk("rst_state_done", {35'h0, init_done}, 36'h0);
`ifdef SRAM_ARB_INIT_EN
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      chk("init_en", {35'h0, rw_en}, 36'h1);
      chk("init_wmode", {35'h0, rw_wmode}, 36'h1);
      chk("init_wdata", rw_wdata, 36'h0);
      chk("init_addr", {33'h0, rw_addr}, 36'(i));
      chk("init_done_low", {35'h0, init_done}, 36'h0);
    end
`endif
    @(negedge clock);
    chk("init_done", {35'h0, init_done}, 36'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1);
  end

  initial begin
    //          wv wa    wd               rv ra    rr | wrdy rrdy rvld en wm
    tbl[0]  = '{1, 3'd3, 36'hA_5A5A_5A5A, 0, 3'd0, 1,   1,   0,   0,   1, 1};
    tbl[1]  = '{0, 3'd0, 36'h0,           1, 3'd3, 1,   0,   1,   0,   1, 0};
    tbl[2]  = '{0, 3'd0, 36'h0,           0, 3'd0, 1,   0,   0,   0,   0, 0};
    tbl[3]  = '{0, 3'd0, 36'h0,           0, 3'd0, 1,   0,   0,   1,   0, 0};
    tbl[4]  = '{1, 3'd0, 36'h111,         1, 3'd3, 1,   0,   1,   0,   1, 0};
    tbl[5]  = '{1, 3'd0, 36'h111,         1, 3'd3, 1,   1,   0,   0,   1, 1};
    tbl[6]  = '{1, 3'd1, 36'h222,         1, 3'd0, 1,   0,   1,   1,   1, 0};
    tbl[7]  = '{1, 3'd1, 36'h222,         1, 3'd0, 1,   1,   0,   0,   1, 1};
    tbl[8]  = '{0, 3'd0, 36'h0,           0, 3'd0, 1,   0,   0,   1,   0, 0};
    tbl[9]  = '{0, 3'd0, 36'h0,           1, 3'd3, 0,   0,   1,   0,   1, 0};
    tbl[10] = '{0, 3'd0, 36'h0,           1, 3'd0, 0,   0,   1,   0,   1, 0};
    tbl[11] = '{0, 3'd0, 36'h0,           1, 3'd1, 0,   0,   0,   1,   0, 0};
    tbl[12] = '{0, 3'd0, 36'h0,           1, 3'd1, 0,   0,   0,   1,   0, 0};
    tbl[13] = '{0, 3'd0, 36'h0,           1, 3'd1, 1,   0,   1,   1,   1, 0};
    tbl[14] = '{0, 3'd0, 36'h0,           1, 3'd3, 1,   0,   1,   1,   1, 0};
    tbl[15] = '{0, 3'd0, 36'h0,           0, 3'd0, 1,   0,   0,   1,   0, 0};
    tbl[16] = '{0, 3'd0, 36'h0,           0, 3'd0, 1,   0,   0,   1,   0, 0};
    tbl[17] = '{0, 3'd0, 36'h0,           0, 3'd0, 1,   0,   0,   0,   0, 0};

    // Reset with both clients requesting: every handshake output must be low.
    reset_n = 1'b0;
    idle();
    w_valid = 1'b1; r_req_valid = 1'b1;
    #12;
    chk("rst_w_ready", {35'h0, w_ready}, 36'h0);
    chk("rst_r_req_ready", {35'h0, r_req_ready}, 36'h0);
    chk("rst_r_resp_valid", {35'h0, r_resp_valid}, 36'h0);
    chk("rst_rw_en", {35'h0, rw_en}, 36'h0);
    chk("rst_rw_wmode", {35'h0, rw_wmode}, 36'h0);
    chk("rst_init_done", {35'h0, init_done}, 36'h0);
    idle();
    step();
    reset_n = 1'b1;

`ifdef SRAM_ARB_INIT_EN
    // Abort the zero-fill during its 4th write, then restart from address 0.
    for (int i = 0; i < 5; i++) @(negedge clock);
    chk("pre_abort_addr", {33'h0, rw_addr}, 36'h3);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_rw_en", {35'h0, rw_en}, 36'h0);
    chk("abort_rw_wmode", {35'h0, rw_wmode}, 36'h0);
    chk("abort_init_done", {35'h0, init_done}, 36'h0);
    step();
    step();
    reset_n = 1'b1;
`endif
    check_init();
    step();

`ifdef SRAM_ARB_INIT_EN
    r_req_valid = 1'b1; r_addr = 3'd5;
    @(negedge clock);
    chk("rd5_ready", {35'h0, r_req_ready}, 36'h1);
    step();
    idle();
    for (int i = 0; i < 3; i++) step();
`endif

    // RAW, conflict alternation and backpressure vectors.
    for (int i = 0; i < 18; i++) begin
      w_valid = tbl[i].wv; w_addr = tbl[i].wa; w_data = tbl[i].wd;
      r_req_valid = tbl[i].rv; r_addr = tbl[i].ra; r_resp_ready = tbl[i].rr;
      @(negedge clock);
      chk($sformatf("v%0d_w_ready", i), {35'h0, w_ready}, {35'h0, tbl[i].e_wrdy});
      chk($sformatf("v%0d_r_req_ready", i), {35'h0, r_req_ready}, {35'h0, tbl[i].e_rrdy});
      chk($sformatf("v%0d_r_resp_valid", i), {35'h0, r_resp_valid}, {35'h0, tbl[i].e_rvld});
      chk($sformatf("v%0d_rw_en", i), {35'h0, rw_en}, {35'h0, tbl[i].e_en});
      if (tbl[i].e_en) chk($sformatf("v%0d_rw_wmode", i), {35'h0, rw_wmode}, {35'h0, tbl[i].e_wm});
      step();
    end
    idle();

    // Sustained throughput: fill 0..7 with 0x100+addr, then read back one per cycle.
    for (int i = 0; i < 8; i++) begin
      w_valid = 1'b1; w_addr = 3'(i); w_data = 36'h100 + 36'(i);
      @(negedge clock);
      chk("tp_w_ready", {35'h0, w_ready}, 36'h1);
      step();
    end
    idle();
    for (int i = 0; i < 8; i++) begin
      r_req_valid = 1'b1; r_addr = 3'(i);
      @(negedge clock);
      chk("tp_r_req_ready", {35'h0, r_req_ready}, 36'h1);
      chk("tp_r_resp_valid", {35'h0, r_resp_valid}, {35'h0, (i >= 2)});
      step();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("tp_tail_valid", {35'h0, r_resp_valid}, {35'h0, (i < 2)});
      step();
    end

    // Fill the FIFO under backpressure, then reset asynchronously.
    r_resp_ready = 1'b0; r_req_valid = 1'b1; r_addr = 3'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("full_r_req_ready", {35'h0, r_req_ready}, {35'h0, (i < 2)});
      if (i < 3) step();
    end
    chk("full_r_resp_valid", {35'h0, r_resp_valid}, 36'h1);
    #1 reset_n = 1'b0;
    #1;
    chk("frst_r_resp_valid", {35'h0, r_resp_valid}, 36'h0);
    chk("frst_r_req_ready", {35'h0, r_req_ready}, 36'h0);
    chk("frst_rw_en", {35'h0, rw_en}, 36'h0);
    chk("frst_init_done", {35'h0, init_done}, 36'h0);
    idle();
    step();
    step();
    reset_n = 1'b1;
    check_init();
    step();
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("post_rst_no_resp", {35'h0, r_resp_valid}, 36'h0);
      step();
    end
    chk("sb_empty", 36'(exp_q.size()), 36'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
